// File: rtl/hazard_control_v3.sv
// Pipeline hazard controller: forwarding selects, load-use stall, cache stall,
// control-transfer flush, multi-cycle EX freeze and saturating event counters.
module hazard_control_v3 #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              id_ex_reg_write,
  input  logic              ex_mem_reg_write,
  input  logic              id_ex_mem_read,
  input  logic              rs_only,
  input  logic              no_dep,
  input  logic              do_jump,
  input  logic              i_rdy,
  input  logic              d_rdy,
  input  logic              mc_start,
  input  logic              stat_clr,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              id_ex_write_en,
  output logic              ex_mem_write_en,
  output logic              mem_wb_write_en,
  output logic              if_id_clean,
  output logic              id_ex_clean,
  output logic              ex_mem_clean,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              mc_busy,
  output logic [STAT_W-1:0] stat_lu,
  output logic [STAT_W-1:0] stat_cache,
  output logic [STAT_W-1:0] stat_mc,
  output logic [STAT_W-1:0] stat_flush
);

  localparam int unsigned     CntW      = $clog2(MC_LAT + 1);
  localparam logic [CntW-1:0] CntLoad   = CntW'(MC_LAT - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam bit              MultiCyc  = (MC_LAT > 1);
  localparam logic [STAT_W-1:0] StatMax = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] StatOne = STAT_W'(1);

  typedef enum logic [0:0] {StRun, StMcBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic cache_stall, jump, mc_freeze, lu_stall;

  logic [STAT_W-1:0] stat_lu_q, stat_cache_q, stat_mc_q, stat_flush_q;

  // Operand dependence on the instructions in EX and MEM
  assign ex_match_a  = ~no_dep & id_ex_reg_write & (id_ex_rd != '0) & (if_id_rs == id_ex_rd);
  assign mem_match_a = ~no_dep & ex_mem_reg_write & (ex_mem_rd != '0) & (if_id_rs == ex_mem_rd);
  assign ex_match_b  = ~no_dep & ~rs_only & id_ex_reg_write & (id_ex_rd != '0) &
                       (if_id_rt == id_ex_rd);
  assign mem_match_b = ~no_dep & ~rs_only & ex_mem_reg_write & (ex_mem_rd != '0) &
                       (if_id_rt == ex_mem_rd);

  assign cache_stall = ~(i_rdy & d_rdy);
  assign jump        = do_jump & ~cache_stall;
  assign lu_stall    = (ex_match_a | ex_match_b) & id_ex_mem_read & ~cache_stall & ~jump &
                       ~mc_freeze;
  assign mc_busy     = (state_q == StMcBusy);

  // Forward selects; a load in EX cannot forward, so that case falls to 00 and stalls
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (ex_match_a && !id_ex_mem_read) forward_a = 2'b01;
    else if (mem_match_a && !ex_match_a) forward_a = 2'b10;
    if (ex_match_b && !id_ex_mem_read) forward_b = 2'b01;
    else if (mem_match_b && !ex_match_b) forward_b = 2'b10;
  end

  // Multi-cycle occupancy: cnt counts remaining EX cycles after the current one
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_freeze = 1'b0;
    if (!cache_stall) begin
      if (jump) begin
        state_d = StRun;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          StRun: begin
            if (mc_start && MultiCyc) begin
              mc_freeze = 1'b1;
              cnt_d     = CntLoad;
              state_d   = StMcBusy;
            end
          end
          StMcBusy: begin
            if (cnt_q > CntOne) begin
              mc_freeze = 1'b1;
              cnt_d     = cnt_q - CntOne;
            end else begin
              // Last EX cycle: let the pipeline advance
              cnt_d   = '0;
              state_d = StRun;
            end
          end
          default: begin
            state_d = StRun;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage enables and flushes in priority order
  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    if_id_clean     = 1'b0;
    id_ex_clean     = 1'b0;
    ex_mem_clean    = 1'b0;
    if (cache_stall) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
    end else if (jump) begin
      if_id_clean  = 1'b1;
      id_ex_clean  = 1'b1;
      ex_mem_clean = 1'b1;
    end else if (mc_freeze) begin
      // Hold the front end, drain a bubble behind the op in EX
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_write_en = 1'b0;
      ex_mem_clean   = 1'b1;
    end else if (lu_stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_clean    = 1'b1;
    end
  end

  // Saturating event counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lu_q    <= '0;
      stat_cache_q <= '0;
      stat_mc_q    <= '0;
      stat_flush_q <= '0;
    end else if (stat_clr) begin
      stat_lu_q    <= '0;
      stat_cache_q <= '0;
      stat_mc_q    <= '0;
      stat_flush_q <= '0;
    end else begin
      if (lu_stall && stat_lu_q != StatMax) stat_lu_q <= stat_lu_q + StatOne;
      if (cache_stall && stat_cache_q != StatMax) stat_cache_q <= stat_cache_q + StatOne;
      if (mc_freeze && stat_mc_q != StatMax) stat_mc_q <= stat_mc_q + StatOne;
      if (jump && stat_flush_q != StatMax) stat_flush_q <= stat_flush_q + StatOne;
    end
  end

  assign stat_lu    = stat_lu_q;
  assign stat_cache = stat_cache_q;
  assign stat_mc    = stat_mc_q;
  assign stat_flush = stat_flush_q;

endmodule

// File: tb/tb_hazard_control_v3.sv
// Randomized and directed bench for hazard_control_v3 against a cycle-level
// reference model of the hazard rules.
module tb_hazard_control_v3;

  localparam int MC_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic       id_ex_reg_write, ex_mem_reg_write, id_ex_mem_read;
  logic       rs_only, no_dep, do_jump, i_rdy, d_rdy, mc_start, stat_clr;

  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_cl, id_ex_cl, ex_mem_cl;
  logic [1:0]  fwd_a, fwd_b;
  logic        busy;
  logic [15:0] s_lu, s_cache, s_mc, s_flush;

  logic        pc_we2, if_id_we2, id_ex_we2, ex_mem_we2, mem_wb_we2;
  logic        if_id_cl2, id_ex_cl2, ex_mem_cl2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic        busy2;
  logic [1:0]  s_lu2, s_cache2, s_mc2, s_flush2;

  int n_chk = 0;
  int n_err = 0;

  // Model state: remaining EX cycles of an in-flight multi-cycle op
  int m_rem, m_lu, m_cache, m_mc, m_flush, m_lu2;
  logic [7:0] e_ctl;
  logic [1:0] e_fa, e_fb;
  bit e_cs, e_jp, e_fr, e_lu;
  int e_occ;

  always #5 clk = ~clk;

  hazard_control_v3 #(.REG_AW(4), .MC_LAT(MC_LAT), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .id_ex_reg_write(id_ex_reg_write),
    .ex_mem_reg_write(ex_mem_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .rs_only(rs_only), .no_dep(no_dep), .do_jump(do_jump), .i_rdy(i_rdy), .d_rdy(d_rdy),
    .mc_start(mc_start), .stat_clr(stat_clr), .pc_write_en(pc_we),
    .if_id_write_en(if_id_we), .id_ex_write_en(id_ex_we), .ex_mem_write_en(ex_mem_we),
    .mem_wb_write_en(mem_wb_we), .if_id_clean(if_id_cl), .id_ex_clean(id_ex_cl),
    .ex_mem_clean(ex_mem_cl), .forward_a(fwd_a), .forward_b(fwd_b), .mc_busy(busy),
    .stat_lu(s_lu), .stat_cache(s_cache), .stat_mc(s_mc), .stat_flush(s_flush)
  );

  // Narrow-counter instance for saturation
  hazard_control_v3 #(.REG_AW(4), .MC_LAT(MC_LAT), .STAT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .id_ex_reg_write(id_ex_reg_write),
    .ex_mem_reg_write(ex_mem_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .rs_only(rs_only), .no_dep(no_dep), .do_jump(do_jump), .i_rdy(i_rdy), .d_rdy(d_rdy),
    .mc_start(mc_start), .stat_clr(stat_clr), .pc_write_en(pc_we2),
    .if_id_write_en(if_id_we2), .id_ex_write_en(id_ex_we2), .ex_mem_write_en(ex_mem_we2),
    .mem_wb_write_en(mem_wb_we2), .if_id_clean(if_id_cl2), .id_ex_clean(id_ex_cl2),
    .ex_mem_clean(ex_mem_cl2), .forward_a(fwd_a2), .forward_b(fwd_b2), .mc_busy(busy2),
    .stat_lu(s_lu2), .stat_cache(s_cache2), .stat_mc(s_mc2), .stat_flush(s_flush2)
  );

  wire [7:0] ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                    if_id_cl, id_ex_cl, ex_mem_cl};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [3:0] src, input logic [3:0] rd, input logic we);
    return we && (rd != 4'd0) && (src == rd);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_eval();
    bit exa, exb, ma, mb;
    exa = !no_dep && hit(if_id_rs, id_ex_rd, id_ex_reg_write);
    ma  = !no_dep && hit(if_id_rs, ex_mem_rd, ex_mem_reg_write);
    exb = !no_dep && !rs_only && hit(if_id_rt, id_ex_rd, id_ex_reg_write);
    mb  = !no_dep && !rs_only && hit(if_id_rt, ex_mem_rd, ex_mem_reg_write);
    e_fa = (exa && !id_ex_mem_read) ? 2'd1 : ((ma && !exa) ? 2'd2 : 2'd0);
    e_fb = (exb && !id_ex_mem_read) ? 2'd1 : ((mb && !exb) ? 2'd2 : 2'd0);
    e_cs = !(i_rdy && d_rdy);
    e_jp = do_jump && !e_cs;
    e_occ = (m_rem > 0) ? m_rem : ((mc_start && MC_LAT > 1) ? MC_LAT : 0);
    e_fr = !e_cs && !e_jp && (e_occ > 1);
    e_lu = (exa || exb) && id_ex_mem_read && !e_cs && !e_jp && !e_fr;
    if (e_cs)      e_ctl = 8'b00000_000;
    else if (e_jp) e_ctl = 8'b11111_111;
    else if (e_fr) e_ctl = 8'b00011_001;
    else if (e_lu) e_ctl = 8'b00111_010;
    else           e_ctl = 8'b11111_000;
  endtask

  task automatic model_step();
    m_lu    = stat_clr ? 0 : sat(m_lu + int'(e_lu), 65535);
    m_cache = stat_clr ? 0 : sat(m_cache + int'(e_cs), 65535);
    m_mc    = stat_clr ? 0 : sat(m_mc + int'(e_fr), 65535);
    m_flush = stat_clr ? 0 : sat(m_flush + int'(e_jp), 65535);
    m_lu2   = stat_clr ? 0 : sat(m_lu2 + int'(e_lu), 3);
    if (!e_cs) m_rem = e_jp ? 0 : ((e_occ > 1) ? e_occ - 1 : 0);
  endtask

  task automatic model_reset();
    m_rem = 0; m_lu = 0; m_cache = 0; m_mc = 0; m_flush = 0; m_lu2 = 0;
  endtask

  // One clock: inputs already driven after a negedge; check, advance model, next negedge
  task automatic cycle();
    #1;
    model_eval();
    check("ctl", 32'(ctl), 32'(e_ctl));
    check("fwd_a", 32'(fwd_a), 32'(e_fa));
    check("fwd_b", 32'(fwd_b), 32'(e_fb));
    check("mc_busy", 32'(busy), 32'(m_rem > 0));
    check("stat_lu", 32'(s_lu), 32'(m_lu));
    check("stat_cache", 32'(s_cache), 32'(m_cache));
    check("stat_mc", 32'(s_mc), 32'(m_mc));
    check("stat_flush", 32'(s_flush), 32'(m_flush));
    check("stat_lu_w2", 32'(s_lu2), 32'(m_lu2));
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    if_id_rs = '0; if_id_rt = '0; id_ex_rd = '0; ex_mem_rd = '0;
    id_ex_reg_write = 0; ex_mem_reg_write = 0; id_ex_mem_read = 0;
    rs_only = 0; no_dep = 0; do_jump = 0; i_rdy = 1; d_rdy = 1;
    mc_start = 0; stat_clr = 0;
  endtask

  task automatic clear_stats();
    idle(); stat_clr = 1; cycle(); stat_clr = 0;
  endtask

  task automatic lu_setup();
    idle(); id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_rd = 4'd5;
    if_id_rt = 4'd5; if_id_rs = 4'd1;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #3;
    check("rst_ctl", 32'(ctl), 32'h00F8);
    check("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stats", 32'({s_lu, s_mc} | {s_cache, s_flush}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Forwarding from EX, EX beats MEM, zero register never forwards
    idle(); id_ex_rd = 4'd3; id_ex_reg_write = 1; if_id_rs = 4'd3;
    #1 check("fwd_ex", 32'(fwd_a), 32'd1); cycle();
    ex_mem_rd = 4'd3; ex_mem_reg_write = 1;
    #1 check("fwd_ex_over_mem", 32'(fwd_a), 32'd1); cycle();
    id_ex_rd = 4'd0; ex_mem_rd = 4'd0; if_id_rs = 4'd0;
    #1 check("fwd_r0", 32'(fwd_a), 32'd0); cycle();

    // Load-use on rt
    clear_stats();
    lu_setup(); rs_only = 1;
    #1 check("lu_rs_only", 32'(ctl), 32'h00F8); cycle();
    rs_only = 0;
    #1 check("lu_stall", 32'(ctl), 32'h003A); cycle();
    idle(); cycle();
    check("lu_count", 32'(s_lu), 32'd1);

    // Multi-cycle op, uninterrupted
    clear_stats();
    mc_start = 1;
    #1 check("mc_first", 32'(ctl), 32'h0019); cycle();
    mc_start = 0;
    for (int i = 0; i < 2; i++) begin
      #1 check("mc_freeze", 32'(ctl), 32'h0019); check("mc_busy_on", 32'(busy), 32'd1);
      cycle();
    end
    #1 check("mc_last", 32'(ctl), 32'h00F8); check("mc_busy_last", 32'(busy), 32'd1);
    cycle();
    check("mc_done", 32'(busy), 32'd0);
    check("mc_count", 32'(s_mc), 32'd3);

    // Cache stall in the middle of a multi-cycle op
    clear_stats();
    mc_start = 1; cycle(); mc_start = 0; cycle();
    d_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      #1 check("mc_cstall", 32'(ctl), 32'h0000); cycle();
    end
    d_rdy = 1;
    #1 check("mc_resume", 32'(ctl), 32'h0019); cycle();
    #1 check("mc_resume_last", 32'(ctl), 32'h00F8); cycle();
    check("cs_count", 32'(s_cache), 32'd5);
    check("cs_mc_count", 32'(s_mc), 32'd3);
    check("cs_done", 32'(busy), 32'd0);

    // Jump aborts a multi-cycle op; jump under cache stall is suppressed
    clear_stats();
    mc_start = 1; cycle(); mc_start = 0;
    do_jump = 1;
    #1 check("jmp_flush", 32'(ctl), 32'h00FF); cycle();
    do_jump = 0;
    #1 check("jmp_abort", 32'(busy), 32'd0); check("jmp_count", 32'(s_flush), 32'd1);
    cycle();
    do_jump = 1; i_rdy = 0;
    #1 check("jmp_istall", 32'(ctl), 32'h0000); cycle();
    idle(); cycle();

    // Saturation of the narrow counter, then clear
    clear_stats();
    lu_setup();
    repeat (5) cycle();
    idle();
    check("sat_w2", 32'(s_lu2), 32'd3);
    check("sat_w16", 32'(s_lu), 32'd5);
    stat_clr = 1; cycle(); stat_clr = 0;
    check("sat_clr", 32'(s_lu2), 32'd0);

    // Reset asserted mid-op aborts at once
    mc_start = 1; cycle(); mc_start = 0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1 check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ctl", 32'(ctl), 32'h00F8);
    check("async_rst_stat", 32'(s_mc), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if_id_rs = 4'($urandom_range(0, 3));
      if_id_rt = 4'($urandom_range(0, 3));
      id_ex_rd = 4'($urandom_range(0, 3));
      ex_mem_rd = 4'($urandom_range(0, 3));
      id_ex_reg_write = 1'($urandom_range(0, 1));
      ex_mem_reg_write = 1'($urandom_range(0, 1));
      id_ex_mem_read = ($urandom_range(0, 2) == 0);
      rs_only = ($urandom_range(0, 4) == 0);
      no_dep = ($urandom_range(0, 4) == 0);
      do_jump = ($urandom_range(0, 9) == 0);
      i_rdy = ($urandom_range(0, 9) != 0);
      d_rdy = ($urandom_range(0, 9) != 0);
      mc_start = ($urandom_range(0, 7) == 0);
      stat_clr = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_control_v3.md
HAZARD_CONTROL_V3 -- requirements
Module: hazard_control_v3

Interface
REQ-001 The block SHALL have parameter REG_AW, default 4, meaning register-address width.
REQ-002 The block SHALL have parameter MC_LAT, default 4, meaning total EX-stage occupancy in cycles of a multi-cycle op; legal values are at least 1.
REQ-003 The block SHALL have parameter STAT_W, default 16, meaning the width of each statistics counter.
REQ-004 The block SHALL have the following ports:
- clk  in  1  the single clock; all state on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_id_rs, if_id_rt  in  REG_AW  source registers of the instruction in ID.
- id_ex_rd, ex_mem_rd  in  REG_AW  destination registers in EX and MEM.
- id_ex_reg_write, ex_mem_reg_write, id_ex_mem_read  in  1  control bits of EX and MEM.
- rs_only  in  1  ID instruction reads rs only (llb/lhb/ret class).
- no_dep  in  1  ID instruction has no register dependence (branch/call/halted).
- do_jump  in  1  taken control transfer resolved downstream.
- i_rdy, d_rdy  in  1  I-cache and D-cache ready.
- mc_start  in  1  multi-cycle op is in EX this cycle (first EX cycle).
- stat_clr  in  1  synchronous clear of the statistics counters.
- pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en  out  1  stage-register write enables.
- if_id_clean, id_ex_clean, ex_mem_clean  out  1  stage-register flushes (bubble insert).
- forward_a, forward_b  out  2  forward selects: 00 none, 01 from EX, 10 from MEM.
- mc_busy  out  1  FSM is in MC_BUSY.
- stat_lu, stat_cache, stat_mc, stat_flush  out  STAT_W  statistics counters.

Function
REQ-005 ex_match_x SHALL be: id_ex_reg_write, id_ex_rd nonzero, and the source register equal to id_ex_rd; mem_match_x SHALL be the same test using ex_mem_*. For the B side, both matches SHALL be forced 0 when rs_only=1; for both sides, all matches SHALL be forced 0 when no_dep=1.
REQ-006 forward_x SHALL be 01 when ex_match_x=1 and id_ex_mem_read=0, and 10 when mem_match_x=1 and ex_match_x=0; otherwise it SHALL be 00. Forward outputs SHALL be combinational and SHALL never be 11.
REQ-007 The block SHALL use the conditions cache_stall = ~(i_rdy & d_rdy), jump = do_jump & ~cache_stall, and lu_stall = (ex_match_a | ex_match_b) & id_ex_mem_read & ~cache_stall & ~jump & ~mc_freeze.
REQ-008 FSM states SHALL be RUN and MC_BUSY, with down-counter cnt of width clog2(MC_LAT+1).
REQ-009 In RUN with mc_start=1, MC_LAT>1, no cache_stall and no jump:
- mc_freeze SHALL be asserted that cycle;
- cnt SHALL load MC_LAT-1 and the state SHALL go to MC_BUSY.
When MC_LAT=1, mc_start SHALL be ignored.
REQ-010 In MC_BUSY:
- mc_freeze SHALL be asserted when cnt>1;
- cnt SHALL decrement each cycle without cache_stall;
- when cnt=1, mc_freeze SHALL be 0 (the last EX cycle, so the pipeline advances) and the next state SHALL be RUN.
The op therefore occupies EX for exactly MC_LAT non-cache-stalled cycles.
REQ-011 While mc_freeze=1, the block SHALL drive pc/if_id/id_ex write_en=0, ex_mem_write_en=1, mem_wb_write_en=1, ex_mem_clean=1, and id_ex_clean=0.
REQ-012 While cache_stall=1, all write_en SHALL be 0 and all clean outputs SHALL be 0, and FSM state and cnt SHALL hold.
REQ-013 While jump=1, if_id_clean, id_ex_clean and ex_mem_clean SHALL be 1, all write_en SHALL be 1, and the FSM SHALL go to RUN with cnt=0 (abort), including from MC_BUSY.
REQ-014 While lu_stall=1, pc/if_id write_en SHALL be 0, id_ex_clean SHALL be 1, and the other write_en SHALL be 1.
REQ-015 Priority SHALL be cache_stall > jump > mc_freeze > lu_stall. With no condition active, all write_en SHALL be 1 and all clean outputs SHALL be 0.
REQ-016 The statistics counters SHALL saturate at all-ones and increment once per cycle of lu_stall (stat_lu), cache_stall (stat_cache), mc_freeze (stat_mc) and jump (stat_flush). stat_clr SHALL zero all four and take priority over increment.

Reset
REQ-017 When rst_n=0, the block SHALL asynchronously force state=RUN, cnt=0, mc_busy=0 and all statistics counters to 0.
REQ-018 During and after reset, with i_rdy=d_rdy=1 and no hazard inputs, the block SHALL output all write_en=1, all clean outputs=0, and forward_a=forward_b=00.
REQ-019 Deassertion of rst_n mid-MC_BUSY SHALL NOT be required; assertion of rst_n mid-MC_BUSY SHALL abort the op to RUN immediately.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- id_ex_rd=3, id_ex_reg_write=1, if_id_rs=3, mem_read=0 -> forward_a=01; same with ex_mem_rd=3 as well -> still 01; rd=0 -> 00.
- Load-use: id_ex_mem_read=1, match on rt, rs_only=1 -> no stall; rs_only=0 -> pc/if_id write_en=0, id_ex_clean=1 for one cycle, stat_lu=1.
- MC_LAT=4, mc_start pulse -> mc_freeze for 3 cycles, mc_busy high for 3 cycles, advance in 4th EX cycle, stat_mc=3.
- MC_BUSY with cnt=2 and d_rdy=0 for 5 cycles -> all write_en 0, cnt holds, stat_cache=5; resumes and completes.
- do_jump in MC_BUSY -> three clean outputs=1, FSM to RUN next cycle; do_jump with i_rdy=0 -> no clean, write_en all 0.
- Counter saturation with STAT_W=2 after 5 lu_stall cycles -> stat_lu=3; stat_clr -> 0.
